// File: rtl/axi4_lite_arbiter_2x1_if.sv
// AXI4-Lite channel bundle; N lanes packed side by side (lane i in slice i).
// The master modport is the transaction initiator, slave the responder.
interface axi4_lite_arbiter_2x1_if #(
    parameter int unsigned N      = 1,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [N*ADDR_W-1:0]   awaddr;
    logic [N*3-1:0]        awprot;
    logic [N-1:0]          awvalid;
    logic [N-1:0]          awready;
    logic [N*DATA_W-1:0]   wdata;
    logic [N*DATA_W/8-1:0] wstrb;
    logic [N-1:0]          wvalid;
    logic [N-1:0]          wready;
    logic [N*2-1:0]        bresp;
    logic [N-1:0]          bvalid;
    logic [N-1:0]          bready;
    logic [N*ADDR_W-1:0]   araddr;
    logic [N*3-1:0]        arprot;
    logic [N-1:0]          arvalid;
    logic [N-1:0]          arready;
    logic [N*DATA_W-1:0]   rdata;
    logic [N*2-1:0]        rresp;
    logic [N-1:0]          rvalid;
    logic [N-1:0]          rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4_lite_arbiter_2x1.sv
// Two-master to one-slave AXI4-Lite arbiter: one transaction at a time,
// round-robin between masters, write before read within a master.
module axi4_lite_arbiter_2x1 #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    axi4_lite_arbiter_2x1_if.slave    m,
    axi4_lite_arbiter_2x1_if.master   s,
    output logic                      grant_id,
    output logic                      busy
);
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WADDR = 3'd1;
    localparam logic [2:0] WRESP = 3'd2;
    localparam logic [2:0] RADDR = 3'd3;
    localparam logic [2:0] RDATA = 3'd4;

    logic [2:0] state;
    logic       last_id;
    logic       aw_done;
    logic       w_done;

    logic [1:0] wreq;
    logic [1:0] req;
    logic       pick;
    logic       pick_wreq;

    logic       in_waddr;
    logic       in_wresp;
    logic       in_raddr;
    logic       in_rdata;
    logic [1:0] own;

    logic       g_awvalid;
    logic       g_wvalid;
    logic       g_bready;
    logic       g_arvalid;
    logic       g_rready;

    logic       aw_ok;
    logic       w_ok;
    logic       aw_fire;
    logic       w_fire;
    logic       b_fire;
    logic       ar_fire;
    logic       r_fire;
    logic       aw_next;
    logic       w_next;

    // Tie goes to the master that did not finish last; otherwise the sole requester.
    assign wreq      = m.awvalid;
    assign req       = m.awvalid | m.arvalid;
    assign pick      = (req[0] & req[1]) ? ~last_id : req[1];
    assign pick_wreq = pick ? wreq[1] : wreq[0];

    assign in_waddr = (state == WADDR);
    assign in_wresp = (state == WRESP);
    assign in_raddr = (state == RADDR);
    assign in_rdata = (state == RDATA);
    assign own      = grant_id ? 2'b10 : 2'b01;
    assign busy     = (state != IDLE);

    assign g_awvalid = grant_id ? m.awvalid[1] : m.awvalid[0];
    assign g_wvalid  = grant_id ? m.wvalid[1]  : m.wvalid[0];
    assign g_bready  = grant_id ? m.bready[1]  : m.bready[0];
    assign g_arvalid = grant_id ? m.arvalid[1] : m.arvalid[0];
    assign g_rready  = grant_id ? m.rready[1]  : m.rready[0];

    // Payload always follows the granted slice; only valids/readys are gated.
    assign s.awaddr = grant_id ? m.awaddr[2*ADDR_W-1:ADDR_W] : m.awaddr[ADDR_W-1:0];
    assign s.awprot = grant_id ? m.awprot[5:3] : m.awprot[2:0];
    assign s.wdata  = grant_id ? m.wdata[2*DATA_W-1:DATA_W] : m.wdata[DATA_W-1:0];
    assign s.wstrb  = grant_id ? m.wstrb[2*STRB_W-1:STRB_W] : m.wstrb[STRB_W-1:0];
    assign s.araddr = grant_id ? m.araddr[2*ADDR_W-1:ADDR_W] : m.araddr[ADDR_W-1:0];
    assign s.arprot = grant_id ? m.arprot[5:3] : m.arprot[2:0];

    assign aw_ok = in_waddr & ~aw_done;
    assign w_ok  = in_waddr & ~w_done;

    assign s.awvalid = aw_ok & g_awvalid;
    assign m.awready = own & {2{aw_ok & s.awready}};
    assign s.wvalid  = w_ok & g_wvalid;
    assign m.wready  = own & {2{w_ok & s.wready}};
    assign s.bready  = in_wresp & g_bready;
    assign m.bvalid  = own & {2{in_wresp & s.bvalid}};
    assign s.arvalid = in_raddr & g_arvalid;
    assign m.arready = own & {2{in_raddr & s.arready}};
    assign s.rready  = in_rdata & g_rready;
    assign m.rvalid  = own & {2{in_rdata & s.rvalid}};

    assign m.bresp = {2{s.bresp}};
    assign m.rresp = {2{s.rresp}};
    assign m.rdata = {2{s.rdata}};

    assign aw_fire = aw_ok & g_awvalid & s.awready;
    assign w_fire  = w_ok & g_wvalid & s.wready;
    assign b_fire  = in_wresp & g_bready & s.bvalid;
    assign ar_fire = in_raddr & g_arvalid & s.arready;
    assign r_fire  = in_rdata & g_rready & s.rvalid;
    assign aw_next = aw_done | aw_fire;
    assign w_next  = w_done | w_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_id <= 1'b0;
            last_id  <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_id <= pick;
                        state    <= pick_wreq ? WADDR : RADDR;
                    end
                end
                WADDR: begin
                    if (aw_next && w_next) begin
                        state   <= WRESP;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_next;
                        w_done  <= w_next;
                    end
                end
                WRESP: begin
                    if (b_fire) begin
                        state   <= IDLE;
                        last_id <= grant_id;
                    end
                end
                RADDR: begin
                    if (ar_fire) state <= RDATA;
                end
                RDATA: begin
                    if (r_fire) begin
                        state   <= IDLE;
                        last_id <= grant_id;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_lite_arbiter_2x1.sv
// Bench for axi4_lite_arbiter_2x1: scoreboarded slave-side forwarding and
// master-side responses, plus cycle-exact arbitration and timing checks.
module tb_axi4_lite_arbiter_2x1;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [31:0] RKEY = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic grant_id;
    logic busy;

    always #5 clk = ~clk;

    axi4_lite_arbiter_2x1_if #(.N(2), .ADDR_W(AW), .DATA_W(DW)) m_if ();
    axi4_lite_arbiter_2x1_if #(.N(1), .ADDR_W(AW), .DATA_W(DW)) s_if ();

    axi4_lite_arbiter_2x1 #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .m        (m_if),
        .s        (s_if),
        .grant_id (grant_id),
        .busy     (busy)
    );

    logic [31:0] awaddr_m [2];
    logic [31:0] wdata_m  [2];
    logic [3:0]  wstrb_m  [2];
    logic [31:0] araddr_m [2];
    logic        awvalid_m[2];
    logic        wvalid_m [2];
    logic        bready_m [2];
    logic        arvalid_m[2];
    logic        rready_m [2];

    assign m_if.awaddr  = {awaddr_m[1], awaddr_m[0]};
    assign m_if.awprot  = {3'b011, 3'b001};
    assign m_if.awvalid = {awvalid_m[1], awvalid_m[0]};
    assign m_if.wdata   = {wdata_m[1], wdata_m[0]};
    assign m_if.wstrb   = {wstrb_m[1], wstrb_m[0]};
    assign m_if.wvalid  = {wvalid_m[1], wvalid_m[0]};
    assign m_if.bready  = {bready_m[1], bready_m[0]};
    assign m_if.araddr  = {araddr_m[1], araddr_m[0]};
    assign m_if.arprot  = {3'b111, 3'b101};
    assign m_if.arvalid = {arvalid_m[1], arvalid_m[0]};
    assign m_if.rready  = {rready_m[1], rready_m[0]};

    logic        s_awready_r = 1'b1;
    logic        s_wready_r  = 1'b1;
    logic        s_bvalid_r  = 1'b1;
    logic [1:0]  s_bresp_r   = 2'b00;
    logic        s_arready_r = 1'b1;
    logic        s_rvalid_r  = 1'b1;
    logic [1:0]  s_rresp_r   = 2'b00;
    logic [31:0] s_rdata_r   = '0;

    assign s_if.awready = s_awready_r;
    assign s_if.wready  = s_wready_r;
    assign s_if.bvalid  = s_bvalid_r;
    assign s_if.bresp   = s_bresp_r;
    assign s_if.arready = s_arready_r;
    assign s_if.rvalid  = s_rvalid_r;
    assign s_if.rresp   = s_rresp_r;
    assign s_if.rdata   = s_rdata_r;

    // Slave model: read data is the accepted address scrambled with RKEY.
    always @(posedge clk) begin
        if (s_if.arvalid && s_arready_r) s_rdata_r <= s_if.araddr ^ RKEY;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    logic [34:0] aw_q[$];
    logic [35:0] w_q[$];
    logic [2:0]  b_q[$];
    logic [34:0] ar_q[$];
    logic [34:0] r_q[$];

    function automatic void exp_wr(input int i, input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] st, input logic [1:0] rsp);
        aw_q.push_back({(i == 1) ? 3'b011 : 3'b001, a});
        w_q.push_back({st, d});
        b_q.push_back({1'(i), rsp});
    endfunction

    function automatic void exp_rd(input int i, input logic [31:0] a);
        ar_q.push_back({(i == 1) ? 3'b111 : 3'b101, a});
        r_q.push_back({1'(i), 2'b00, a ^ RKEY});
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (s_if.awvalid && s_awready_r) begin
                if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
                else check("aw_fwd", {s_if.awprot, s_if.awaddr}, aw_q.pop_front());
            end
            if (s_if.wvalid && s_wready_r) begin
                if (w_q.size() == 0) check("w_unexpected", 1, 0);
                else check("w_fwd", {s_if.wstrb, s_if.wdata}, w_q.pop_front());
            end
            if (s_if.arvalid && s_arready_r) begin
                if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
                else check("ar_fwd", {s_if.arprot, s_if.araddr}, ar_q.pop_front());
            end
            for (int i = 0; i < 2; i++) begin
                if (m_if.bvalid[i] && bready_m[i]) begin
                    if (b_q.size() == 0) check("b_unexpected", 1, 0);
                    else check("b_resp", {1'(i), m_if.bresp[2*i +: 2]}, b_q.pop_front());
                end
                if (m_if.rvalid[i] && rready_m[i]) begin
                    if (r_q.size() == 0) check("r_unexpected", 1, 0);
                    else check("r_data", {1'(i), m_if.rresp[2*i +: 2], m_if.rdata[32*i +: 32]},
                               r_q.pop_front());
                end
            end
        end
    end

    function automatic logic sig(input int which, input int i);
        case (which)
            0:       return m_if.awready[i];
            1:       return m_if.wready[i];
            2:       return m_if.bvalid[i];
            3:       return m_if.arready[i];
            default: return m_if.rvalid[i];
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int which, input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(which, i) && n < 100);
        if (!sig(which, i)) check(tag, 0, 1);
    endtask

    task automatic mwrite(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] st, input int aw_lag);
        bready_m[i] = 1'b1;
        fork
            begin
                repeat (aw_lag) @(posedge clk);
                if (aw_lag > 0) #1;
                awaddr_m[i]  = a;
                awvalid_m[i] = 1'b1;
                wait_sig("aw_timeout", 0, i);
                @(posedge clk); #1;
                awvalid_m[i] = 1'b0;
            end
            begin
                wdata_m[i]  = d;
                wstrb_m[i]  = st;
                wvalid_m[i] = 1'b1;
                wait_sig("w_timeout", 1, i);
                @(posedge clk); #1;
                wvalid_m[i] = 1'b0;
            end
        join
        wait_sig("b_timeout", 2, i);
        @(posedge clk); #1;
    endtask

    task automatic mread(input int i, input logic [31:0] a, input int rdly);
        rready_m[i]  = (rdly == 0);
        araddr_m[i]  = a;
        arvalid_m[i] = 1'b1;
        wait_sig("ar_timeout", 3, i);
        @(posedge clk); #1;
        arvalid_m[i] = 1'b0;
        wait_sig("r_timeout", 4, i);
        if (rdly > 0) begin
            repeat (rdly) @(posedge clk);
            #1 rready_m[i] = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        rready_m[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            awaddr_m[i] = '0; wdata_m[i] = '0; wstrb_m[i] = '0; araddr_m[i] = '0;
            awvalid_m[i] = 1'b0; wvalid_m[i] = 1'b0; bready_m[i] = 1'b0;
            arvalid_m[i] = 1'b0; rready_m[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_handshakes", {s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready,
                                 m_if.awready, m_if.wready, m_if.bvalid, m_if.arready, m_if.rvalid}, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // single write from master 0, zero-wait slave
        exp_wr(0, 32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
        fork
            mwrite(0, 32'h10, 32'hDEADBEEF, 4'hF, 0);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check("t1_m1_quiet", {m_if.awready[1], m_if.wready[1], m_if.bvalid[1],
                                      m_if.arready[1], m_if.rvalid[1]}, 0);
                case (c)
                    0: check("t1_c0_busy", busy, 0);
                    1: check("t1_c1_fwd", {s_if.awvalid, s_if.wvalid, grant_id, busy}, 4'b1101);
                    2: check("t1_c2_bvalid", m_if.bvalid, 2'b01);
                    default: check("t1_c3_busy", busy, 0);
                endcase
            end
        join

        // tied reads straight after reset: master 0 first, then master 1
        #1 reset = 1'b1;
        #1 check("t2_rst_busy", busy, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        exp_rd(0, 32'h20);
        exp_rd(1, 32'h24);
        fork
            mread(0, 32'h20, 0);
            mread(1, 32'h24, 0);
            begin
                @(negedge clk); check("t2_c0_busy", busy, 0);
                @(negedge clk); check("t2_c1_grant", {busy, grant_id, m_if.arready}, 4'b1001);
                @(negedge clk); check("t2_c2_rvalid", m_if.rvalid, 2'b01);
                @(negedge clk); check("t2_c3_idle", busy, 0);
                @(negedge clk); check("t2_c4_grant", {busy, grant_id, m_if.arready}, 4'b1110);
            end
        join

        // master 1: W leads AW by two cycles, slave AW stalled, error response
        @(posedge clk); #1;
        s_awready_r = 1'b0;
        s_bresp_r   = 2'b10;
        exp_wr(1, 32'h40, 32'h12345678, 4'hF, 2'b10);
        fork
            mwrite(1, 32'h40, 32'h12345678, 4'hF, 2);
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("t3_c3_waddr", {busy, grant_id, s_if.awvalid, s_if.wvalid}, 4'b1111);
                @(posedge clk);
                @(negedge clk);
                check("t3_c4_wdone", {s_if.awvalid, s_if.wvalid, m_if.wready, m_if.bvalid}, 6'b100000);
                @(posedge clk); #1;
                s_awready_r = 1'b1;
                @(negedge clk);
                check("t3_c5_nob", m_if.bvalid, 2'b00);
                @(posedge clk);
                @(negedge clk);
                check("t3_c6_bresp", {m_if.bvalid, m_if.bresp[3:2]}, 4'b1010);
            end
        join
        s_bresp_r = 2'b00;

        // master 0 with AW and AR together: write, idle, read = 7 cycles
        @(posedge clk); #1;
        exp_wr(0, 32'h80, 32'hCAFEF00D, 4'h3, 2'b00);
        exp_rd(0, 32'h84);
        fork
            mwrite(0, 32'h80, 32'hCAFEF00D, 4'h3, 0);
            mread(0, 32'h84, 0);
            begin
                @(negedge clk); check("t4_c0", busy, 0);
                @(negedge clk); check("t4_c1", {busy, s_if.awvalid, s_if.arvalid}, 3'b110);
                @(negedge clk); check("t4_c2", {busy, m_if.bvalid}, 3'b101);
                @(negedge clk); check("t4_c3", busy, 0);
                @(negedge clk); check("t4_c4", {busy, grant_id, s_if.awvalid, s_if.arvalid}, 4'b1001);
                @(negedge clk); check("t4_c5", {busy, m_if.rvalid}, 3'b101);
                @(negedge clk); check("t4_c6", busy, 0);
            end
        join

        // slave stalls AR, master 0 stalls R, master 1 waits throughout
        @(posedge clk); #1;
        s_arready_r = 1'b0;
        exp_rd(0, 32'h100);
        exp_wr(1, 32'h104, 32'h0BADF00D, 4'hC, 2'b00);
        fork
            mread(0, 32'h100, 3);
            begin
                @(posedge clk); #1;
                mwrite(1, 32'h104, 32'h0BADF00D, 4'hC, 0);
            end
            begin
                @(negedge clk); check("t5_c0", busy, 0);
                @(posedge clk);
                for (int c = 1; c <= 4; c++) begin
                    @(negedge clk);
                    check("t5_ar_stall", {busy, grant_id, s_if.arvalid, m_if.awready}, 5'b10100);
                    @(posedge clk);
                end
                #1 s_arready_r = 1'b1;
                @(negedge clk);
                @(posedge clk);
                for (int c = 6; c <= 8; c++) begin
                    @(negedge clk);
                    check("t5_r_stall", {m_if.rvalid, s_if.rready, m_if.awready}, 5'b01000);
                    @(posedge clk);
                end
                @(negedge clk); check("t5_c9_rready", s_if.rready, 1);
                @(posedge clk);
                @(negedge clk); check("t5_c10_idle", {busy, grant_id}, 2'b00);
                @(posedge clk);
                @(negedge clk); check("t5_c11_m1", {busy, grant_id, s_if.awvalid}, 3'b111);
            end
        join

        // reset while in WRESP, then a tie must go to master 0
        @(posedge clk); #1;
        aw_q.push_back({3'b001, 32'h200});
        w_q.push_back({4'hF, 32'h55AA55AA});
        awaddr_m[0] = 32'h200; wdata_m[0] = 32'h55AA55AA; wstrb_m[0] = 4'hF;
        awvalid_m[0] = 1'b1; wvalid_m[0] = 1'b1; bready_m[0] = 1'b0;
        @(negedge clk); check("t6_c0", busy, 0);
        @(negedge clk); check("t6_c1", {busy, s_if.awvalid, s_if.wvalid}, 3'b111);
        @(posedge clk); #1;
        awvalid_m[0] = 1'b0; wvalid_m[0] = 1'b0;
        @(negedge clk); check("t6_wresp", {busy, m_if.bvalid}, 3'b101);
        #2 reset = 1'b1;
        #1 check("t6_async_drop", {busy, m_if.bvalid, s_if.bready, s_if.awvalid, s_if.arvalid}, 0);
        @(negedge clk) reset = 1'b0;
        bready_m[0] = 1'b1;
        @(posedge clk); #1;
        exp_wr(0, 32'h300, 32'h01020304, 4'hF, 2'b00);
        exp_wr(1, 32'h304, 32'hA0B0C0D0, 4'h5, 2'b00);
        fork
            mwrite(0, 32'h300, 32'h01020304, 4'hF, 0);
            mwrite(1, 32'h304, 32'hA0B0C0D0, 4'h5, 0);
            begin
                @(negedge clk);
                @(negedge clk); check("t6_tie_first", {busy, grant_id}, 2'b10);
                @(negedge clk);
                @(negedge clk); check("t6_gap", busy, 0);
                @(negedge clk); check("t6_tie_second", {busy, grant_id}, 2'b11);
            end
        join

        repeat (2) @(posedge clk);
        check("sb_drained", aw_q.size() + w_q.size() + b_q.size() + ar_q.size() + r_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi4_lite_arbiter_2x1.md
# axi4_lite_arbiter_2x1

Two-master to one-slave AXI4-Lite arbiter that shares a single AXI4-Lite slave port between two requesting masters. It sits between two AXI4-Lite masters and the AXI4-Lite slave block. It serialises all write and read transactions one at a time, using round-robin between the masters and write-before-read within a master. It forwards each granted transaction's channels to the slave and routes responses back to the owner.

## Interface

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8. Strobe width is DATA_W/8.

Ports. Master-side buses are packed, master i in slice i.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- Master write-address channel:
  - m_awaddr in 2*ADDR_W
  - m_awprot in 6
  - m_awvalid in 2
  - m_awready out 2
- Master write-data channel:
  - m_wdata in 2*DATA_W
  - m_wstrb in 2*DATA_W/8
  - m_wvalid in 2
  - m_wready out 2
- Master write-response channel:
  - m_bresp out 4
  - m_bvalid out 2
  - m_bready in 2
- Master read-address channel:
  - m_araddr in 2*ADDR_W
  - m_arprot in 6
  - m_arvalid in 2
  - m_arready out 2
- Master read-data channel:
  - m_rdata out 2*DATA_W
  - m_rresp out 4
  - m_rvalid out 2
  - m_rready in 2
- Slave channels (s_awaddr, s_awprot, s_awvalid, s_awready, s_wdata, s_wstrb, s_wvalid, s_wready, s_bresp, s_bvalid, s_bready, s_araddr, s_arprot, s_arvalid, s_arready, s_rdata, s_rresp, s_rvalid, s_rready): single-master widths, directions mirrored (slave-side valids/data are outputs, readys are outputs only for B/R).
- grant_id  out  1  index of the master owning the slave port.
- busy  out  1  high when the state is not IDLE.

## Operation

- States: IDLE, WADDR, WRESP, RADDR, RDATA. Registers:
  - state
  - grant_id
  - last_id (last completed owner)
  - aw_done, w_done
- Request of master i: wreq_i = m_awvalid[i]; rreq_i = m_arvalid[i]; req_i = wreq_i | rreq_i.
- IDLE arbitration:
  - If both masters request, grant !last_id. Otherwise grant the sole requester.
  - Granted master goes to WADDR if wreq, else RADDR (write wins within a master).
  - With no request, stay in IDLE.
- WADDR:
  - s_awvalid = m_awvalid[g] & ~aw_done and m_awready[g] = s_awready & ~aw_done.
  - s_wvalid = m_wvalid[g] & ~w_done and m_wready[g] = s_wready & ~w_done.
  - AW and W complete independently, in either order or the same cycle, setting aw_done/w_done.
  - When both are complete, go to WRESP and clear both flags.
- WRESP:
  - s_bready = m_bready[g] and m_bvalid[g] = s_bvalid.
  - On handshake, go to IDLE with last_id <= g.
- RADDR:
  - s_arvalid = m_arvalid[g] and m_arready[g] = s_arready.
  - On handshake, go to RDATA.
- RDATA:
  - s_rready = m_rready[g] and m_rvalid[g] = s_rvalid.
  - On handshake, go to IDLE with last_id <= g.
- Slave addr/prot/data/strb outputs always mux the grant_id slice.
- m_bresp, m_rresp and m_rdata broadcast the slave values to both slices. Only the owner's valid is raised.
- Non-owner m_*ready and m_*valid are 0 at all times. All valid/ready outputs are decoded from the registered state, and all are 0 in IDLE.
- grant_id changes only on the IDLE exit edge.
- A master that asserts a request while the other owns the port waits; its valid is held per AXI rules and is not checked.

## Timing

- Reset (async assert, sync release):
  - state = IDLE, last_id = 1 (master 0 wins the first tie), grant_id = 0, aw_done = w_done = 0.
  - Every valid/ready output is 0 immediately on assertion. busy = 0.
- Arbitration latency: one cycle. A request sampled in IDLE at edge N is forwarded to the slave in cycle N+1.
- Minimum write with a zero-wait slave: 3 cycles (IDLE, WADDR, WRESP). Minimum read: 3 cycles (IDLE, RADDR, RDATA).
- There is exactly one IDLE cycle between consecutive transactions, including back-to-back requests from the same master.
- Both masters requesting continuously alternate 0,1,0,1…
- A master with both AW and AR valid gets its write first. The read follows only after the other master's pending request, if any, is served.
- Reset asserted mid-transaction drops all forwarded valids in the same cycle. The transaction is abandoned; the slave and masters must be reset together.

## Test plan

- Single write, master 0: awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF with zero-wait slave, bresp=0 -> s_awvalid/s_wvalid high cycle 1; m_bvalid[0] cycle 2; busy low cycle 3; m_*[1] never asserted.
- Simultaneous read requests from both masters right after reset: araddr 0x20 (m0), 0x24 (m1) -> m0 served first, rdata returned only with m_rvalid[0]; m1 granted after one IDLE cycle; grant_id sequence 0 then 1.
- Master 1 drives W two cycles before AW (awaddr=0x40, wdata=0x12345678) -> w_done set first; no WRESP until AW handshake; s_bresp=2'b10 arrives on m_bresp[3:2] with m_bvalid[1].
- Master 0 asserts awvalid and arvalid together, master 1 idle -> write completes, then the read is granted; 7 cycles total with a zero-wait slave.
- Slave stalls: s_arready low 4 cycles, s_rvalid held with m_rready[0] low 3 cycles -> state holds RADDR then RDATA; master 1 request pending throughout is not granted until return to IDLE.
- Reset asserted in WRESP -> m_bvalid, s_bready and busy fall without a clock edge; after release, the first tie grants master 0.
